// File: rtl/robs_divider.sv
// robs_divider: sequential signed restoring divider.
// A 2*WIDTH-bit two's-complement dividend is divided by a WIDTH-bit divisor,
// one shift-subtract step per clock, followed by one sign-fix cycle.
// Handshake: a reset pulse (0-1-0) loads the operands and starts the operation;
// done rises 2*WIDTH+1 edges after the last reset-high edge and the results
// (quotient, remainder, overflow, div_by_zero) then hold until the next reset.
module robs_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 overflow,
  output logic                 div_by_zero,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  localparam logic [1:0] ST_ITER = 2'd0;
  localparam logic [1:0] ST_FIX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;        // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [WIDTH:0]   rem_q, rem_d;        // partial remainder
  logic             neg_dvd_q, neg_dvd_d;
  logic             neg_dvs_q, neg_dvs_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             overflow_q, overflow_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // Operand magnitudes; the most negative values map to their exact unsigned magnitude.
  logic [DW-1:0]    dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  assign dvd_abs = dividend[DW-1] ? (DW'(0) - dividend) : dividend;
  assign dvs_abs = divisor[WIDTH-1] ? (WIDTH'(0) - divisor) : divisor;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  assign shifted = {rem_q, dvd_q[DW-1]};
  assign q_bit   = (shifted >= {2'b00, dvs_q});
  assign trial   = shifted[WIDTH:0] - {1'b0, dvs_q};

  // Sign fix-up on the full-width quotient so overflow detection is exact.
  logic [DW-1:0]    q_signed;
  logic [WIDTH-1:0] r_signed;
  logic             q_fits;
  assign q_signed = (neg_dvd_q ^ neg_dvs_q) ? (DW'(0) - dvd_q) : dvd_q;
  assign r_signed = neg_dvd_q ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  assign q_fits   = (&q_signed[DW-1:WIDTH-1]) | ~(|q_signed[DW-1:WIDTH-1]);

  // Next-state logic: reset loads operands; otherwise ITER steps, FIX signs results, DONE holds.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    neg_dvd_d   = neg_dvd_q;
    neg_dvs_d   = neg_dvs_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;
    done_d      = done_q;
    if (reset) begin
      dvd_d       = dvd_abs;
      dvs_d       = dvs_abs;
      neg_dvd_d   = dividend[DW-1];
      neg_dvs_d   = divisor[WIDTH-1];
      zero_d      = (divisor == '0);
      rem_d       = '0;
      cnt_d       = '0;
      state_d     = ST_ITER;
      quotient_d  = '0;
      remainder_d = '0;
      overflow_d  = 1'b0;
      dbz_d       = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ITER: begin
          rem_d = q_bit ? trial : shifted[WIDTH:0];
          dvd_d = {dvd_q[DW-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (zero_q) begin
            quotient_d  = '0;
            remainder_d = '0;
            overflow_d  = 1'b1;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = q_signed[WIDTH-1:0];
            remainder_d = r_signed;
            overflow_d  = ~q_fits;
            dbz_d       = 1'b0;
          end
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_DONE;
        end
      endcase
    end
  end

  // State registers; reset is folded into the next-state logic as the operand load.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    dvd_q       <= dvd_d;
    dvs_q       <= dvs_d;
    rem_q       <= rem_d;
    neg_dvd_q   <= neg_dvd_d;
    neg_dvs_q   <= neg_dvs_d;
    zero_q      <= zero_d;
    quotient_q  <= quotient_d;
    remainder_q <= remainder_d;
    overflow_q  <= overflow_d;
    dbz_q       <= dbz_d;
    done_q      <= done_d;
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
